// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard/forwarding scoreboard: tracks in-flight writers after ID,
// raises load-use stalls, selects the ID write-back bypass and registered EX forwarding.

module hazard_scoreboard_match #(
  parameter int RW = 5
) (
  input  logic          v,
  input  logic          wen,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] src,
  input  logic          use_src,
  output logic          hit
);
  assign hit = v & wen & use_src & (src != '0) & (rd == src);
endmodule

module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int NREG     = 32,
  parameter int SELW     = $clog2(DEPTH),
  parameter int CNTW     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [$clog2(NREG)-1:0]  id_rs1,
  input  logic [$clog2(NREG)-1:0]  id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [$clog2(NREG)-1:0]  id_rd,
  input  logic                     id_wen,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic                     id_wb_byp_rs1,
  output logic                     id_wb_byp_rs2,
  output logic [SELW-1:0]          ex_fwd_rs1,
  output logic [SELW-1:0]          ex_fwd_rs2,
  output logic [CNTW-1:0]          stall_cnt
);
  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          wen;
    logic          ld;
  } entry_t;

  entry_t [DEPTH-1:0]       ent_pipe;
  entry_t                   ent_new;
  logic [1:0][RW-1:0]       src;
  logic [1:0]               src_use;
  logic [1:0][DEPTH-1:0]    hit;
  logic [1:0]               nrdy;
  logic [1:0]               byp;
  logic [1:0][SELW-1:0]     fwd_nxt;
  logic [1:0][SELW-1:0]     fwd_q;
  logic                     issue;

  assign src     = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
      hazard_scoreboard_match #(.RW(RW)) u_match (
        .v       (ent_pipe[k].v),
        .wen     (ent_pipe[k].wen),
        .rd      (ent_pipe[k].rd),
        .src     (src[s]),
        .use_src (src_use[s]),
        .hit     (hit[s][k])
      );
    end
  end

  // Scan oldest to youngest so the youngest hit overwrites the result.
  always_comb begin
    nrdy    = '0;
    byp     = '0;
    fwd_nxt = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hit[s][k]) begin
          nrdy[s]    = ent_pipe[k].ld && (k + 1 < LOAD_RDY);
          byp[s]     = (k == DEPTH - 1);
          fwd_nxt[s] = (k < DEPTH - 1) ? SELW'(k + 1) : '0;
        end
      end
    end
  end

  assign stall         = ~reset & id_valid & ~flush & (|nrdy);
  assign id_wb_byp_rs1 = ~reset & byp[0];
  assign id_wb_byp_rs2 = ~reset & byp[1];
  assign issue         = id_valid & ~stall & ~flush;

  always_comb begin
    ent_new = '0;
    if (issue) begin
      ent_new.v   = 1'b1;
      ent_new.rd  = id_rd;
      ent_new.wen = id_wen & (id_rd != '0);
      ent_new.ld  = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_pipe  <= '0;
      fwd_q     <= '0;
      stall_cnt <= '0;
    end else begin
      ent_pipe[DEPTH-1:1] <= ent_pipe[DEPTH-2:0];
      ent_pipe[0]         <= ent_new;
      fwd_q               <= issue ? fwd_nxt : '0;
      if (stall && (stall_cnt != {CNTW{1'b1}}))
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

  assign ex_fwd_rs1 = fwd_q[0];
  assign ex_fwd_rs2 = fwd_q[1];
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (DEPTH=3/LOAD_RDY=2 and DEPTH=5/LOAD_RDY=3/CNTW=4)
// share stimulus and are checked every cycle against a last-writer timestamp model.

module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wen = 1'b0, id_is_load = 1'b0;
  logic       flush = 1'b0;

  logic        a_stall, a_b1, a_b2;
  logic [1:0]  a_f1, a_f2;
  logic [31:0] a_cnt;
  logic        b_stall, b_b1, b_b2;
  logic [2:0]  b_f1, b_f2;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .LOAD_RDY(2), .NREG(32), .CNTW(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .stall(a_stall), .id_wb_byp_rs1(a_b1),
    .id_wb_byp_rs2(a_b2), .ex_fwd_rs1(a_f1), .ex_fwd_rs2(a_f2), .stall_cnt(a_cnt));

  hazard_scoreboard #(.DEPTH(5), .LOAD_RDY(3), .NREG(32), .CNTW(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .stall(b_stall), .id_wb_byp_rs1(b_b1),
    .id_wb_byp_rs2(b_b2), .ex_fwd_rs1(b_f1), .ex_fwd_rs2(b_f2), .stall_cnt(b_cnt));

  int     checks = 0, pass = 0;
  int     cyc = 0;
  int     md[2] = '{3, 5};
  int     ml[2] = '{2, 3};
  longint mmax[2] = '{64'hffff_ffff, 64'd15};
  string  nm[2] = '{"A", "B"};

  // Model: for each register, the cycle its most recent writer left ID.
  bit     has[2][32];
  int     lc[2][32];
  bit     lld[2][32];
  int     efwd1[2], efwd2[2];
  longint ecnt[2];

  logic   act_st[2], act_b1[2], act_b2[2];
  int     act_f1[2], act_f2[2];
  longint act_cnt[2];

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 32; r++) begin has[m][r] = 0; lc[m][r] = 0; lld[m][r] = 0; end
      efwd1[m] = 0; efwd2[m] = 0; ecnt[m] = 0;
    end
  endfunction

  function automatic void src_info(input int m, input int s, input bit u,
                                   output bit found, output int k, output bit ld);
    found = 0; k = 0; ld = 0;
    if (u && s != 0 && has[m][s]) begin
      k = cyc - lc[m][s] - 1;
      if (k >= 0 && k < md[m]) begin found = 1; ld = lld[m][s]; end
    end
  endfunction

  task automatic set_ins(input bit v, input int rd, input bit wen, input bit ld,
                         input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid = v; id_rd = 5'(rd); id_wen = wen; id_is_load = ld;
    id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
  endtask

  // One clock: compare both DUTs at negedge, then advance the model.
  task automatic cycle();
    bit f1, f2, l1, l2, est, eb1, eb2, iss;
    int k1, k2;
    @(negedge clk);
    act_st[0] = a_stall; act_b1[0] = a_b1; act_b2[0] = a_b2;
    act_f1[0] = int'(a_f1); act_f2[0] = int'(a_f2); act_cnt[0] = longint'(a_cnt);
    act_st[1] = b_stall; act_b1[1] = b_b1; act_b2[1] = b_b2;
    act_f1[1] = int'(b_f1); act_f2[1] = int'(b_f2); act_cnt[1] = longint'(b_cnt);
    for (int m = 0; m < 2; m++) begin
      src_info(m, int'(id_rs1), id_use_rs1, f1, k1, l1);
      src_info(m, int'(id_rs2), id_use_rs2, f2, k2, l2);
      est = !reset && id_valid && !flush &&
            ((f1 && l1 && k1 + 1 < ml[m]) || (f2 && l2 && k2 + 1 < ml[m]));
      eb1 = !reset && f1 && k1 == md[m] - 1;
      eb2 = !reset && f2 && k2 == md[m] - 1;
      checks++; if (act_st[m] !== est) $display("FAIL %s_stall got=%0d exp=%0d cyc=%0d", nm[m], act_st[m], est, cyc); else pass++;
      checks++; if (act_b1[m] !== eb1) $display("FAIL %s_byp1 got=%0d exp=%0d cyc=%0d", nm[m], act_b1[m], eb1, cyc); else pass++;
      checks++; if (act_b2[m] !== eb2) $display("FAIL %s_byp2 got=%0d exp=%0d cyc=%0d", nm[m], act_b2[m], eb2, cyc); else pass++;
      checks++; if (act_f1[m] !== efwd1[m]) $display("FAIL %s_fwd1 got=%0d exp=%0d cyc=%0d", nm[m], act_f1[m], efwd1[m], cyc); else pass++;
      checks++; if (act_f2[m] !== efwd2[m]) $display("FAIL %s_fwd2 got=%0d exp=%0d cyc=%0d", nm[m], act_f2[m], efwd2[m], cyc); else pass++;
      checks++; if (act_cnt[m] !== ecnt[m]) $display("FAIL %s_cnt got=%0d exp=%0d cyc=%0d", nm[m], act_cnt[m], ecnt[m], cyc); else pass++;
      if (reset) begin
        for (int r = 0; r < 32; r++) has[m][r] = 0;
        efwd1[m] = 0; efwd2[m] = 0; ecnt[m] = 0;
      end else begin
        iss = id_valid && !est && !flush;
        efwd1[m] = (iss && f1 && k1 < md[m] - 1) ? k1 + 1 : 0;
        efwd2[m] = (iss && f2 && k2 < md[m] - 1) ? k2 + 1 : 0;
        if (est && ecnt[m] < mmax[m]) ecnt[m]++;
        if (iss && id_wen && id_rd != 0) begin
          has[m][id_rd] = 1; lc[m][id_rd] = cyc; lld[m][id_rd] = id_is_load;
        end
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); flush = 0;
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    reset = 1; set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1; model_clear(); cyc = 0;
    cycle();
    reset = 0;
    checks++; if (act_st[0] !== 1'b0 || act_f1[0] !== 0 || act_cnt[0] !== 0)
      $display("FAIL reset_state got=%0d/%0d/%0d exp=0/0/0", act_st[0], act_f1[0], act_cnt[0]); else pass++;
    drain(2);
  endtask

  task automatic test_back_to_back();
    set_ins(1, 5, 1, 0, 1, 1, 2, 1); cycle();
    set_ins(1, 6, 1, 0, 5, 1, 1, 1); cycle();
    checks++; if (act_st[0] !== 1'b0) $display("FAIL b2b_stall got=%0d exp=0", act_st[0]); else pass++;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[0] !== 1) $display("FAIL b2b_fwd1 got=%0d exp=1", act_f1[0]); else pass++;
    drain(6);
  endtask

  task automatic test_load_use();
    longint c0 = longint'(a_cnt);
    int n = 0;
    set_ins(1, 5, 1, 1, 0, 0, 0, 0); cycle();
    set_ins(1, 7, 1, 0, 5, 1, 5, 1); cycle();
    while (act_st[0] === 1'b1 && n < 8) begin n++; cycle(); end
    checks++; if (n !== 1) $display("FAIL lu_stall_cycles got=%0d exp=1", n); else pass++;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[0] !== 2 || act_f2[0] !== 2) $display("FAIL lu_fwd got=%0d/%0d exp=2/2", act_f1[0], act_f2[0]); else pass++;
    checks++; if (act_cnt[0] - c0 !== 1) $display("FAIL lu_cnt got=%0d exp=1", act_cnt[0] - c0); else pass++;
    drain(6);
  endtask

  task automatic test_distance3();
    set_ins(1, 5, 1, 0, 0, 0, 0, 0); cycle();
    drain(2);
    set_ins(1, 8, 1, 0, 5, 1, 0, 1); cycle();
    checks++; if (act_st[0] !== 1'b0 || act_b1[0] !== 1'b1) $display("FAIL d3_byp got=%0d/%0d exp=0/1", act_st[0], act_b1[0]); else pass++;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[0] !== 0) $display("FAIL d3_fwd1 got=%0d exp=0", act_f1[0]); else pass++;
    drain(6);
  endtask

  task automatic test_youngest_x0();
    set_ins(1, 5, 1, 0, 0, 0, 0, 0); cycle();
    set_ins(1, 5, 1, 0, 0, 0, 0, 0); cycle();
    set_ins(1, 9, 1, 0, 5, 1, 0, 1); cycle();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[0] !== 1 || act_f2[0] !== 0) $display("FAIL yw_fwd got=%0d/%0d exp=1/0", act_f1[0], act_f2[0]); else pass++;
    set_ins(1, 0, 1, 1, 0, 0, 0, 0); cycle();
    set_ins(1, 3, 1, 0, 0, 1, 0, 1); cycle();
    checks++; if (act_st[0] !== 1'b0 || act_st[1] !== 1'b0) $display("FAIL x0_stall got=%0d/%0d exp=0/0", act_st[0], act_st[1]); else pass++;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[0] !== 0 || act_f2[0] !== 0) $display("FAIL x0_fwd got=%0d/%0d exp=0/0", act_f1[0], act_f2[0]); else pass++;
    drain(6);
  endtask

  task automatic test_param_flush();
    int n = 0;
    set_ins(1, 4, 1, 1, 0, 0, 0, 0); cycle();
    set_ins(1, 3, 1, 0, 4, 1, 0, 1); cycle();
    while (act_st[1] === 1'b1 && n < 10) begin n++; cycle(); end
    checks++; if (n !== 2) $display("FAIL p5_stall_cycles got=%0d exp=2", n); else pass++;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[1] !== 3) $display("FAIL p5_fwd1 got=%0d exp=3", act_f1[1]); else pass++;
    drain(8);
    set_ins(1, 4, 1, 1, 0, 0, 0, 0); cycle();
    set_ins(1, 3, 1, 0, 4, 1, 0, 1); cycle();
    checks++; if (act_st[1] !== 1'b1) $display("FAIL fl_pre_stall got=%0d exp=1", act_st[1]); else pass++;
    flush = 1; cycle();
    checks++; if (act_st[1] !== 1'b0) $display("FAIL fl_stall got=%0d exp=0", act_st[1]); else pass++;
    flush = 0; set_ins(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    checks++; if (act_f1[1] !== 0) $display("FAIL fl_fwd1 got=%0d exp=0", act_f1[1]); else pass++;
    drain(8);
  endtask

  task automatic test_reset_mid_stall();
    set_ins(1, 4, 1, 1, 0, 0, 0, 0); cycle();
    set_ins(1, 3, 1, 0, 4, 1, 0, 1); cycle();
    reset = 1; cycle();
    checks++; if (act_st[0] !== 1'b0 || act_st[1] !== 1'b0) $display("FAIL rs_during got=%0d/%0d exp=0/0", act_st[0], act_st[1]); else pass++;
    reset = 0; cycle();
    checks++; if (act_st[1] !== 1'b0 || act_cnt[1] !== 0) $display("FAIL rs_after got=%0d/%0d exp=0/0", act_st[1], act_cnt[1]); else pass++;
    drain(8);
  endtask

  task automatic test_saturation();
    int n = 0, guard = 0;
    while (n < 20 && guard < 200) begin
      set_ins(1, 4, 1, 1, 0, 0, 0, 0); cycle(); guard++;
      set_ins(1, 3, 1, 0, 4, 1, 0, 0); cycle(); guard++;
      while (act_st[1] === 1'b1 && guard < 200) begin n++; cycle(); guard++; end
      if (act_st[1] === 1'b1) n++;
    end
    checks++; if (n < 20) $display("FAIL sat_timeout got=%0d exp=20", n); else pass++;
    drain(1);
    checks++; if (act_cnt[1] !== 15) $display("FAIL sat_cnt got=%0d exp=15", act_cnt[1]); else pass++;
    reset = 1; cycle(); reset = 0; drain(1);
    checks++; if (act_cnt[1] !== 0) $display("FAIL sat_reset got=%0d exp=0", act_cnt[1]); else pass++;
  endtask

  task automatic test_random();
    repeat (600) begin
      set_ins($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1));
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 0; flush = 0;
    drain(6);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_distance3();
    test_youngest_x0();
    test_param_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass, checks);
    $finish;
  end
endmodule
